// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the uart core's transmit data register.
// Bytes are pushed at any rate. The FSM writes them one at a time through the
// core's CSR port and waits for tx_irq before it issues the next byte.
// Optional feature: define UART_TXQ_TIMEOUT_EN to add a WAIT watchdog and the
// sticky timeout output.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | nothing in flight; dequeue the head byte when the queue is not empty
//   S_ISSUE | csr_we strobe to the core for one cycle
//   S_WAIT  | byte in flight; wait for tx_irq (or the watchdog when enabled)
module uart_tx_queue #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_overflow,
    output logic          busy,
    output logic [13:0]   csr_a,
    output logic          csr_we,
    output logic [31:0]   csr_di,
    input  logic          tx_irq
`ifdef UART_TXQ_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    // Catch inconsistent parameter sets at elaboration
    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_depth
        $error("uart_tx_queue: DEPTH must be a power of two >= 2 and equal 2**AW");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_queue: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_nxt;
    logic          full_q, empty_q, overflow_q;
    logic [7:0]    tx_byte;
    state_t        state_q, state_nxt;
    logic          push, pop;

    // full is taken from the registered count, so a pop in the same cycle
    // does not rescue a push into a full queue
    assign push = wr_en & ~full_q;

`ifdef UART_TXQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;
    logic          tmo_hit;
    logic          timeout_q;
`endif

    // Next-state logic; the dequeue happens on the IDLE -> ISSUE transition
    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (tx_irq) begin
                    state_nxt = S_IDLE;
                end
`ifdef UART_TXQ_TIMEOUT_EN
                else if (wait_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Occupancy after this edge
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Storage array; no reset because it holds only data and is gated by count
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count, registered flags and the sticky overflow flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            if (clr_overflow) begin
                overflow_q <= 1'b0;
            end else if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // State register and the byte being sent
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            tx_byte <= '0;
        end else begin
            state_q <= state_nxt;
            if (pop) begin
                tx_byte <= mem[rd_ptr];
            end
        end
    end

`ifdef UART_TXQ_TIMEOUT_EN
    // WAIT watchdog: loaded while in ISSUE, counts down to terminal count in WAIT
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt <= TMO_LOAD;
        end else if (state_q == S_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Sticky timeout flag, cleared together with overflow
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timeout_q <= 1'b0;
        end else if (clr_overflow) begin
            timeout_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`endif

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE);
    assign csr_a    = '0;
    assign csr_we   = (state_q == S_ISSUE);
    assign csr_di   = {24'h0, tx_byte};

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a vector table for the queue/overflow behaviour,
// plus hand sequences for latency, ordering, wrap, reset and the watchdog.
// Every strobe is checked against a scoreboard of bytes the bench expects.
module tb_uart_tx_queue;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          full, empty, overflow, busy, csr_we;
    logic [AW:0]   count;
    logic          clr_overflow = 1'b0;
    logic [13:0]   csr_a;
    logic [31:0]   csr_di;
    logic          tx_irq = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    logic          timeout;
`endif

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(100)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy),
        .csr_a        (csr_a),
        .csr_we       (csr_we),
        .csr_di       (csr_di),
        .tx_irq       (tx_irq)
`ifdef UART_TXQ_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = -1;
    logic [7:0] sb_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       irq;
        logic       clr;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       bsy;
        logic       ov;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic void addv(input logic wr, input logic [7:0] d, input logic irq,
                                 input logic clr, input int cnt, input logic emp,
                                 input logic ful, input logic bsy, input logic ov);
        vecs.push_back('{wr, d, irq, clr, 5'(cnt), emp, ful, bsy, ov});
    endfunction

    // Strobe monitor: each csr_we cycle must carry the next scoreboard byte
    always @(negedge sys_clk) begin
        if (csr_we) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: csr_di=%08h with no byte expected (cycle %0d)", csr_di, cyc);
            end else begin
                check("strobe_data", csr_di, {24'h0, sb_q.pop_front()});
                check("strobe_addr", 32'(csr_a), 32'h0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, output int pc);
        wr_en = 1'b1;
        wr_data = d;
        sb_q.push_back(d);
        tick();
        pc = cyc;
        wr_en = 1'b0;
    endtask

    task automatic wait_strobe(input int target, output bit ok);
        int b = 0;
        while (strobe_cnt < target && b < 400) begin
            tick();
            b++;
        end
        ok = (strobe_cnt >= target);
        if (!ok) begin
            n_checks++;
            $display("FAIL strobe_wait: saw %0d strobes, required %0d", strobe_cnt, target);
        end
    endtask

    // Answer n strobes with tx_irq dly cycles later; each strobe must come one
    // edge after the reference (push edge for the first, irq edge afterwards)
    task automatic drain(input int n, input int dly, input int ref_cyc, input int base);
        int r = ref_cyc;
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_strobe(base + i + 1, ok);
            if (!ok) return;
            check("strobe_timing", 32'(last_strobe_cyc), 32'(r + 1));
            repeat (dly) tick();
            tx_irq = 1'b1;
            tick();
            r = cyc;
            tx_irq = 1'b0;
        end
    endtask

    initial begin
        int pc, pc0, base;
        bit ok;
        logic prev_full;

        // ---- reset values ----
        repeat (3) tick();
        check("rst_empty", 32'(empty), 1);
        check("rst_count", 32'(count), 0);
        check("rst_csr_we", 32'(csr_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_csr_di", csr_di, 0);
        sys_rst_n = 1'b1;
        tick();

        // ---- vector table: stray irq, fill, overflow, clear priority ----
        for (int i = 0; i < 10; i++) addv(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
        addv(1, 8'h10, 0, 0, 1, 0, 0, 0, 0);
        addv(0, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        addv(1, 8'h11, 1, 0, 1, 0, 0, 1, 0);
        for (int i = 2; i <= 16; i++) addv(1, 8'(8'h10 + i), 0, 0, i, 0, (i == 16), 1, 0);
        addv(1, 8'h21, 0, 0, 16, 0, 1, 1, 1);
        addv(0, 8'h00, 0, 1, 16, 0, 1, 1, 0);
        addv(1, 8'h22, 0, 1, 16, 0, 1, 1, 0);
        addv(1, 8'h23, 0, 0, 16, 0, 1, 1, 1);
        addv(0, 8'h00, 1, 0, 16, 0, 1, 0, 1);
        addv(0, 8'h00, 0, 0, 15, 0, 0, 1, 1);
        addv(1, 8'h24, 0, 0, 16, 0, 1, 1, 1);
        addv(0, 8'h00, 1, 1, 16, 0, 1, 0, 0);

        prev_full = 1'b0;
        foreach (vecs[i]) begin
            wr_en = vecs[i].wr;
            wr_data = vecs[i].d;
            tx_irq = vecs[i].irq;
            clr_overflow = vecs[i].clr;
            if (vecs[i].wr && !prev_full) sb_q.push_back(vecs[i].d);
            tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
            prev_full = vecs[i].ful;
        end
        wr_en = 1'b0;
        tx_irq = 1'b0;
        clr_overflow = 1'b0;
        drain(16, 3, cyc, strobe_cnt);
        check("table_drained", 32'(sb_q.size()), 0);

        // ---- single byte latency ----
        repeat (3) tick();
        base = strobe_cnt;
        push_byte(8'hA5, pc);
        wait_strobe(base + 1, ok);
        check("single_latency", 32'(last_strobe_cyc), 32'(pc + 1));
        repeat (5) tick();
        check("single_one_strobe", 32'(strobe_cnt), 32'(base + 1));
        check("single_busy", 32'(busy), 1);
        tx_irq = 1'b1;
        tick();
        tx_irq = 1'b0;
        check("single_idle", 32'(busy), 0);

        // ---- ordering and irq-to-strobe spacing ----
        tick();
        base = strobe_cnt;
        push_byte(8'h01, pc0);
        for (int i = 2; i <= 5; i++) push_byte(8'(i), pc);
        drain(5, 20, pc0, base);

        // ---- simultaneous push/pop, then wrap with 40 bytes ----
        repeat (3) tick();
        base = strobe_cnt;
        push_byte(8'h70, pc0);
        check("pp_count_before", 32'(count), 1);
        push_byte(8'h71, pc);
        check("pp_count_same", 32'(count), 1);
        drain(2, 4, pc0, base);
        for (int c = 0; c < 4; c++) begin
            tick();
            base = strobe_cnt;
            push_byte(8'($urandom_range(0, 255)), pc0);
            for (int i = 1; i < 10; i++) push_byte(8'($urandom_range(0, 255)), pc);
            drain(10, 2, pc0, base);
        end
        check("wrap_drained", 32'(sb_q.size()), 0);

        // ---- reset in WAIT with 3 bytes queued ----
        tick();
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h61 + i), pc);
        wait_strobe(base + 1, ok);
        repeat (2) tick();
        check("mid_count", 32'(count), 3);
        check("mid_busy", 32'(busy), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_csr_di", csr_di, 0);
        check("mid_rst_csr_we", 32'(csr_we), 0);
        sb_q.delete();
        repeat (2) tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tx_irq = (i % 5 == 0);
            tick();
        end
        tx_irq = 1'b0;
        check("post_rst_no_strobe", 32'(strobe_cnt), 32'(base + 1));
        check("post_rst_empty", 32'(empty), 1);

`ifdef UART_TXQ_TIMEOUT_EN
        // ---- watchdog: WAIT lasts 100 cycles, then the next byte goes ----
        base = strobe_cnt;
        push_byte(8'hB1, pc);
        push_byte(8'hB2, pc);
        wait_strobe(base + 1, ok);
        pc0 = last_strobe_cyc;
        repeat (50) tick();
        check("tmo_busy_mid", 32'(busy), 1);
        check("tmo_flag_mid", 32'(timeout), 0);
        wait_strobe(base + 2, ok);
        check("tmo_reissue", 32'(last_strobe_cyc), 32'(pc0 + 102));
        check("tmo_flag", 32'(timeout), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("tmo_clear", 32'(timeout), 0);
        tx_irq = 1'b1;
        tick();
        tx_irq = 1'b0;
        check("tmo_idle", 32'(busy), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
